// File: rtl/beat_sequencer.sv
// beat_sequencer: steps a STEPS-long rhythm pattern on each tempo beat and
//   emits note_on / gate / accent for hit steps, plus bar position tracking.
// Latency: 1 cycle from a processed beat to note_on, gate rise and step change.
// Backpressure: none; beats are accepted whenever run=1 and dropped otherwise.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset, overrides all other inputs
//   beat         one-cycle tempo pulse from the beat generator
//   run          1 = advance on beats, 0 = pause (step and bar_count hold)
//   pattern_sel  requested pattern; latched only at bar wrap or while idle
//   step         index of the next step to play (0..STEPS-1)
//   note_on      one-cycle strobe for a hit step
//   gate         high for GATE_CYCLES cycles from each note_on (retriggerable)
//   accent       accent bit of the most recent hit, forced 0 while gate=0
//   bar_pulse    one-cycle strobe when step wraps STEPS-1 -> 0
//   bar_count    completed bars, modulo 256
module beat_sequencer #(
  parameter int STEPS       = 16,
  parameter int GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       beat,
  input  logic       run,
  input  logic [1:0] pattern_sel,
  output logic [3:0] step,
  output logic       note_on,
  output logic       gate,
  output logic       accent,
  output logic       bar_pulse,
  output logic [7:0] bar_count
);

  // A zero-length gate would swallow every note, so it is stretched to one cycle.
  localparam int GC = (GATE_CYCLES < 1) ? 1 : GATE_CYCLES;
  localparam int GW = $clog2(GC + 1);

  localparam logic [3:0]    LAST_STEP   = 4'(STEPS - 1);
  localparam logic [GW-1:0] GATE_LOAD   = GW'(GC);
  localparam logic [GW-1:0] GATE_ONE    = GW'(1);
  localparam logic [15:0]   ACCENT_MASK = 16'h0101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GATE = 2'd2
  } state_t;

  function automatic logic [15:0] pattern_of(input logic [1:0] sel);
    logic [15:0] p;
    case (sel)
      2'd0:    p = 16'h1111;
      2'd1:    p = 16'h5555;
      2'd2:    p = 16'h0909;
      default: p = 16'hFFFF;
    endcase
    return p;
  endfunction

  state_t        r_state;
  logic [3:0]    r_step;
  logic [7:0]    r_bar_count;
  logic [1:0]    r_active_sel;
  logic [GW-1:0] r_gate_cnt;
  logic          r_note_on;
  logic          r_gate;
  logic          r_accent;
  logic          r_bar_pulse;

  logic [15:0]   w_pattern;
  logic          w_beat_go;
  logic          w_hit;
  logic          w_wrap;

  // A beat counts in every state once run is high: from IDLE the same-cycle
  // beat is played as the first beat after the transition to WAIT.
  assign w_pattern = pattern_of(r_active_sel);
  assign w_beat_go = run & beat;
  assign w_hit     = w_beat_go & w_pattern[r_step];
  assign w_wrap    = w_beat_go & (r_step == LAST_STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_step       <= 4'd0;
      r_bar_count  <= 8'd0;
      r_active_sel <= pattern_sel;
      r_gate_cnt   <= '0;
      r_note_on    <= 1'b0;
      r_gate       <= 1'b0;
      r_accent     <= 1'b0;
      r_bar_pulse  <= 1'b0;
    end else begin
      r_note_on   <= w_hit;
      r_bar_pulse <= w_wrap;

      if (w_beat_go) begin
        r_step <= w_wrap ? 4'd0 : r_step + 4'd1;
      end
      if (w_wrap) begin
        r_bar_count <= r_bar_count + 8'd1;
      end

      // Pattern changes only take effect at a bar boundary or while idle so a
      // bar never plays a mix of two patterns.
      if ((r_state == S_IDLE) || w_wrap) begin
        r_active_sel <= pattern_sel;
      end

      if (!run) begin
        // Pause: kill any running gate, keep step/bar position for resume.
        r_state    <= S_IDLE;
        r_gate     <= 1'b0;
        r_accent   <= 1'b0;
        r_gate_cnt <= '0;
      end else if (w_hit) begin
        // New hit (re)loads the gate; takes priority over a same-cycle expiry
        // so a retriggered gate never shows a low cycle.
        r_state    <= S_GATE;
        r_gate     <= 1'b1;
        r_accent   <= ACCENT_MASK[r_step];
        r_gate_cnt <= GATE_LOAD;
      end else if (r_state == S_GATE) begin
        // Misses leave the countdown running; the counter holds the number of
        // high cycles remaining including the current one.
        if (r_gate_cnt <= GATE_ONE) begin
          r_state    <= S_WAIT;
          r_gate     <= 1'b0;
          r_accent   <= 1'b0;
          r_gate_cnt <= '0;
        end else begin
          r_gate_cnt <= r_gate_cnt - GATE_ONE;
        end
      end else if (r_state == S_IDLE) begin
        r_state <= S_WAIT;
      end
    end
  end

  assign step      = r_step;
  assign note_on   = r_note_on;
  assign gate      = r_gate;
  assign accent    = r_accent;
  assign bar_pulse = r_bar_pulse;
  assign bar_count = r_bar_count;

endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: directed scenarios followed by randomized beats/run/sel/reset,
//   every cycle compared against an event-time reference model.
// Latency/backpressure: not applicable (bench).
module tb_beat_sequencer;

  localparam int STEPS = 16;
  localparam int G     = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       beat = 1'b0;
  logic       run = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [3:0] step;
  logic       note_on;
  logic       gate;
  logic       accent;
  logic       bar_pulse;
  logic [7:0] bar_count;

  beat_sequencer #(.STEPS(STEPS), .GATE_CYCLES(G)) dut (
    .clk         (clk),
    .reset       (reset),
    .beat        (beat),
    .run         (run),
    .pattern_sel (pattern_sel),
    .step        (step),
    .note_on     (note_on),
    .gate        (gate),
    .accent      (accent),
    .bar_pulse   (bar_pulse),
    .bar_count   (bar_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: gate is described by the last cycle it must be high,
  // not by a countdown.
  logic [15:0] pats [4] = '{16'h1111, 16'h5555, 16'h0909, 16'hFFFF};
  logic [15:0] acc_mask = 16'h0101;
  int cyc          = 0;
  int m_step       = 0;
  int m_bars       = 0;
  int m_active     = 0;
  int m_gate_until = -1;
  bit m_running    = 0;
  bit m_acc        = 0;
  bit m_note       = 0;
  bit m_barp       = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_update();
    bit go;
    bit hit;
    if (reset) begin
      m_step = 0; m_bars = 0; m_active = int'(pattern_sel);
      m_running = 0; m_gate_until = -1; m_acc = 0; m_note = 0; m_barp = 0;
    end else begin
      go = run && beat;
      m_note = 0;
      m_barp = 0;
      if (go) begin
        hit = pats[m_active][m_step];
        if (hit) begin
          m_gate_until = cyc + G;
          m_note = 1;
          m_acc = acc_mask[m_step];
        end
        if (m_step == STEPS - 1) begin
          m_step = 0;
          m_barp = 1;
          m_bars = (m_bars + 1) % 256;
        end else begin
          m_step = m_step + 1;
        end
      end
      if (!m_running || m_barp) m_active = int'(pattern_sel);
      if (!run) begin
        m_running = 0;
        m_gate_until = -1;
      end else begin
        m_running = 1;
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    bit exp_gate;
    exp_gate = (cyc <= m_gate_until);
    chk("step",      32'(step),      32'(m_step));
    chk("note_on",   32'(note_on),   32'(m_note));
    chk("gate",      32'(gate),      32'(exp_gate));
    chk("accent",    32'(accent),    32'(exp_gate ? m_acc : 1'b0));
    chk("bar_pulse", 32'(bar_pulse), 32'(m_barp));
    chk("bar_count", 32'(bar_count), 32'(m_bars));
  endtask

  task automatic tick(input logic b, input logic r, input logic [1:0] s, input logic rs);
    beat = b; run = r; pattern_sel = s; reset = rs;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  int n_notes;
  int n_acc;
  int n_gate_hi;
  int n_bars;
  int n_gate_lo;
  logic [1:0] rsel;

  initial begin
    // Reset state
    tick(0, 0, 2'd0, 1);
    tick(0, 0, 2'd0, 1);
    chk("reset_step", 32'(step), 32'd0);
    chk("reset_gate", 32'(gate), 32'd0);
    chk("reset_bars", 32'(bar_count), 32'd0);

    // Pattern 0 at one beat per 10 cycles over a full bar
    n_notes = 0; n_acc = 0; n_gate_hi = 0; n_bars = 0;
    for (int b = 0; b < 16; b++) begin
      for (int c = 0; c < 10; c++) begin
        tick(c == 0, 1, 2'd0, 0);
        if (note_on === 1'b1) begin
          n_notes++;
          if (accent === 1'b1) n_acc++;
        end
        if (gate === 1'b1) n_gate_hi++;
        if (bar_pulse === 1'b1) n_bars++;
      end
    end
    chk("t1_notes", 32'(n_notes), 32'd4);
    chk("t1_accents", 32'(n_acc), 32'd2);
    chk("t1_gate_cycles", 32'(n_gate_hi), 32'd16);
    chk("t2_bar_pulses", 32'(n_bars), 32'd1);
    chk("t2_step", 32'(step), 32'd0);
    chk("t2_bar_count", 32'(bar_count), 32'd1);

    // Mid-bar pattern request is deferred to the next wrap
    for (int b = 0; b < 5; b++) begin
      tick(1, 1, 2'd0, 0); tick(0, 1, 2'd0, 0); tick(0, 1, 2'd0, 0);
    end
    chk("t3_step5", 32'(step), 32'd5);
    n_notes = 0;
    for (int b = 5; b < 16; b++) begin
      tick(1, 1, 2'd3, 0);
      if (note_on === 1'b1) n_notes++;
      tick(0, 1, 2'd3, 0); tick(0, 1, 2'd3, 0);
    end
    chk("t3_old_pattern_notes", 32'(n_notes), 32'd2);
    chk("t3_bar_count", 32'(bar_count), 32'd2);

    // All-hit pattern at one beat per 2 cycles: gate never drops
    n_notes = 0; n_gate_lo = 0;
    for (int b = 0; b < 16; b++) begin
      tick(1, 1, 2'd3, 0);
      if (note_on === 1'b1) n_notes++;
      if (gate !== 1'b1) n_gate_lo++;
      tick(0, 1, 2'd3, 0);
      if (gate !== 1'b1) n_gate_lo++;
    end
    chk("t4_notes", 32'(n_notes), 32'd16);
    chk("t4_gate_low_cycles", 32'(n_gate_lo), 32'd0);

    // Pause at step 6 with the gate running, then resume
    for (int b = 0; b < 6; b++) begin
      tick(1, 1, 2'd3, 0); tick(0, 1, 2'd3, 0);
    end
    chk("t5_gate_before_pause", 32'(gate), 32'd1);
    tick(0, 0, 2'd3, 0);
    chk("t5_gate_paused", 32'(gate), 32'd0);
    for (int c = 0; c < 6; c++) tick(c[0], 0, 2'd3, 0);
    chk("t5_step_held", 32'(step), 32'd6);
    tick(1, 1, 2'd3, 0);
    chk("t5_resume_note", 32'(note_on), 32'd1);
    chk("t5_resume_step", 32'(step), 32'd7);
    tick(0, 1, 2'd3, 0);

    // Reset in the middle of a gate at step 9
    for (int b = 0; b < 2; b++) begin
      tick(1, 1, 2'd3, 0); tick(0, 1, 2'd3, 0);
    end
    chk("t6_step9", 32'(step), 32'd9);
    tick(0, 1, 2'd3, 1);
    chk("t6_gate", 32'(gate), 32'd0);
    chk("t6_step", 32'(step), 32'd0);
    chk("t6_bars", 32'(bar_count), 32'd0);
    chk("t6_strobes", 32'({note_on, bar_pulse, accent}), 32'd0);

    // Randomized traffic
    rsel = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rsel = 2'($urandom_range(0, 3));
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 9) != 0, rsel,
           $urandom_range(0, 399) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
